// File: rtl/cxu_arb_pkg.sv
// Shared types and helpers for the CXU-L2 requester arbiter.
//   CXU_STATUS_W : width of the CXU-L2 response status field
//   route_idx_t  : route index wide enough for the largest supported N_REQ (8)
//   idx_w()      : route index width for a given requester count (min 1 bit)
//   fifo_ptr_w() : route FIFO pointer width (address bits plus a wrap bit)
package cxu_arb_pkg;

  localparam int unsigned CXU_STATUS_W = 3;
  localparam int unsigned MAX_REQ      = 8;

  typedef logic [$clog2(MAX_REQ)-1:0] route_idx_t;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned fifo_ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/cxu_route_fifo.sv
// Synchronous FIFO of route indices (which requester owns each outstanding request).
// Ports:
//   clk, rst (async, active-high), clk_en (all state holds when 0)
//   push/din : enqueue a route index (ignored while full)
//   pop      : dequeue the head (ignored while empty)
//   full, empty, head : status and current head entry
// DEPTH must be a power of two, at least 2.
module cxu_route_fifo
  import cxu_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clk_en,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int unsigned PW = fifo_ptr_w(DEPTH);
  localparam int unsigned AW = PW - 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic          do_push, do_pop;

  // Extra MSB distinguishes full (wrap bits differ) from empty (pointers equal).
  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_push = clk_en && push && !full;
  assign do_pop  = clk_en && pop && !empty;
  assign head    = mem[rd_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/cxu_l2_arb.sv
// Round-robin arbiter sharing one downstream CXU-L2 port among N_REQ requesters.
// Ports:
//   clk, rst (async, active-high), clk_en (all state holds when 0)
//   up_req_*  : per-requester request channels (flat vectors, requester i in slice i)
//   up_resp_* : per-requester response valid/ready; id/status/data broadcast
//   req_*     : downstream request channel (winner's fields, zero latency)
//   resp_*    : downstream in-order response channel
//   err       : sticky, set when a response arrives with nothing outstanding
module cxu_l2_arb
  import cxu_arb_pkg::*;
#(
  parameter int unsigned N_REQ      = 2,
  parameter int unsigned MAX_OUT    = 4,
  parameter int unsigned CXU_ID_W   = 1,
  parameter int unsigned STATE_ID_W = 1,
  parameter int unsigned FUNC_ID_W  = 10,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ID_W       = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clk_en,
  input  logic [N_REQ-1:0]              up_req_valid,
  output logic [N_REQ-1:0]              up_req_ready,
  input  logic [N_REQ*ID_W-1:0]         up_req_id,
  input  logic [N_REQ*CXU_ID_W-1:0]     up_req_cxu,
  input  logic [N_REQ*STATE_ID_W-1:0]   up_req_state,
  input  logic [N_REQ*FUNC_ID_W-1:0]    up_req_func,
  input  logic [N_REQ*DATA_W-1:0]       up_req_data0,
  input  logic [N_REQ*DATA_W-1:0]       up_req_data1,
  output logic [N_REQ-1:0]              up_resp_valid,
  input  logic [N_REQ-1:0]              up_resp_ready,
  output logic [ID_W-1:0]               up_resp_id,
  output logic [CXU_STATUS_W-1:0]       up_resp_status,
  output logic [DATA_W-1:0]             up_resp_data,
  output logic                          req_valid,
  input  logic                          req_ready,
  output logic [ID_W-1:0]               req_id,
  output logic [CXU_ID_W-1:0]           req_cxu,
  output logic [STATE_ID_W-1:0]         req_state,
  output logic [FUNC_ID_W-1:0]          req_func,
  output logic [DATA_W-1:0]             req_data0,
  output logic [DATA_W-1:0]             req_data1,
  input  logic                          resp_valid,
  output logic                          resp_ready,
  input  logic [ID_W-1:0]               resp_id,
  input  logic [CXU_STATUS_W-1:0]       resp_status,
  input  logic [DATA_W-1:0]             resp_data,
  output logic                          err
);

  localparam int unsigned RW = idx_w(N_REQ);

  logic [RW-1:0] rr_q, lock_idx_q, cand, sel, head;
  logic          lock_q, err_q;
  logic          fifo_full, fifo_empty;
  logic          sel_valid, req_hs, resp_hs;

  // Candidate: first valid requester at or after rr_q, wrapping.
  always_comb begin
    int unsigned j;
    logic        found;
    j     = 0;
    found = 1'b0;
    cand  = rr_q;
    for (int i = 0; i < N_REQ; i++) begin
      j = (int'(rr_q) + i) % N_REQ;
      if (!found && up_req_valid[j[RW-1:0]]) begin
        found = 1'b1;
        cand  = j[RW-1:0];
      end
    end
  end

  // A stalled grant stays locked so the presented request cannot change.
  assign sel = lock_q ? lock_idx_q : cand;

  always_comb begin
    sel_valid = 1'b0;
    req_id    = '0;
    req_cxu   = '0;
    req_state = '0;
    req_func  = '0;
    req_data0 = '0;
    req_data1 = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (RW'(i) == sel) begin
        sel_valid = up_req_valid[i];
        req_id    = up_req_id[i*ID_W +: ID_W];
        req_cxu   = up_req_cxu[i*CXU_ID_W +: CXU_ID_W];
        req_state = up_req_state[i*STATE_ID_W +: STATE_ID_W];
        req_func  = up_req_func[i*FUNC_ID_W +: FUNC_ID_W];
        req_data0 = up_req_data0[i*DATA_W +: DATA_W];
        req_data1 = up_req_data1[i*DATA_W +: DATA_W];
      end
    end
  end

  // Full blocks acceptance regardless of a same-cycle pop: no resp_* -> req_* path.
  assign req_valid = !rst && !fifo_full && (lock_q ? sel_valid : |up_req_valid);
  assign req_hs    = req_valid && req_ready;

  always_comb begin
    up_req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      up_req_ready[i] = req_hs && (RW'(i) == sel);
    end
  end

  // Responses route to the FIFO head; with nothing outstanding they are drained.
  always_comb begin
    up_resp_valid = '0;
    resp_ready    = 1'b1;
    for (int i = 0; i < N_REQ; i++) begin
      if (RW'(i) == head && !fifo_empty) begin
        up_resp_valid[i] = resp_valid && !rst;
        resp_ready       = up_resp_ready[i];
      end
    end
  end

  assign resp_hs        = resp_valid && resp_ready && !fifo_empty;
  assign up_resp_id     = resp_id;
  assign up_resp_status = resp_status;
  assign up_resp_data   = resp_data;
  assign err            = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      err_q      <= 1'b0;
    end else if (clk_en) begin
      if (req_hs) begin
        rr_q   <= (sel == RW'(N_REQ - 1)) ? '0 : sel + 1'b1;
        lock_q <= 1'b0;
      end else if (req_valid) begin
        lock_q     <= 1'b1;
        lock_idx_q <= sel;
      end
      if (resp_valid && fifo_empty) err_q <= 1'b1;
    end
  end

  cxu_route_fifo #(
    .DEPTH (MAX_OUT),
    .W     (RW)
  ) u_route_fifo (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .push   (req_hs),
    .din    (sel),
    .pop    (resp_hs),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .head   (head)
  );

endmodule

// File: tb/tb_cxu_l2_arb.sv
// Self-checking bench for cxu_l2_arb (N_REQ=2, MAX_OUT=4). Expected routes and
// response data are queued as requests are accepted and compared as responses return.
module tb_cxu_l2_arb;
  import cxu_arb_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst, clk_en;
  logic [1:0]              up_req_valid, up_req_ready;
  logic [7:0]              up_req_id;
  logic [1:0]              up_req_cxu, up_req_state;
  logic [19:0]             up_req_func;
  logic [63:0]             up_req_data0, up_req_data1;
  logic [1:0]              up_resp_valid, up_resp_ready;
  logic [3:0]              up_resp_id;
  logic [CXU_STATUS_W-1:0] up_resp_status;
  logic [31:0]             up_resp_data;
  logic                    req_valid, req_ready;
  logic [3:0]              req_id;
  logic                    req_cxu, req_state;
  logic [9:0]              req_func;
  logic [31:0]             req_data0, req_data1;
  logic                    resp_valid, resp_ready;
  logic [3:0]              resp_id;
  logic [CXU_STATUS_W-1:0] resp_status;
  logic [31:0]             resp_data;
  logic                    err;

  int          checks   = 0;
  int          failures = 0;
  int          exp_grant[$];
  int          exp_route[$];
  logic [31:0] exp_data[$];

  always #5 clk = ~clk;

  cxu_l2_arb #(
    .N_REQ(2), .MAX_OUT(4), .CXU_ID_W(1), .STATE_ID_W(1),
    .FUNC_ID_W(10), .DATA_W(32), .ID_W(4)
  ) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .up_req_valid(up_req_valid), .up_req_ready(up_req_ready), .up_req_id(up_req_id),
    .up_req_cxu(up_req_cxu), .up_req_state(up_req_state), .up_req_func(up_req_func),
    .up_req_data0(up_req_data0), .up_req_data1(up_req_data1),
    .up_resp_valid(up_resp_valid), .up_resp_ready(up_resp_ready), .up_resp_id(up_resp_id),
    .up_resp_status(up_resp_status), .up_resp_data(up_resp_data),
    .req_valid(req_valid), .req_ready(req_ready), .req_id(req_id), .req_cxu(req_cxu),
    .req_state(req_state), .req_func(req_func), .req_data0(req_data0),
    .req_data1(req_data1), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_status(resp_status), .resp_data(resp_data), .err(err)
  );

  function automatic logic [1:0] oh(input int r);
    logic [1:0] one;
    one = 2'b01;
    return one << r;
  endfunction

  function automatic logic [3:0] exp_id(input int r);
    return (r == 0) ? 4'h5 : 4'hC;
  endfunction

  function automatic logic [31:0] exp_d0(input int r);
    return (r == 0) ? 32'hA0A0_0000 : 32'hB1B1_0001;
  endfunction

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; up_req_valid = 2'b11; req_ready = 1'b1; resp_valid = 1'b0;
    #2;
    checks++;
    if (req_valid !== 1'b0 || up_req_ready !== 2'b00) begin
      failures++;
      $display("FAIL reset_req req_valid=%b up_req_ready=%b want 0/00", req_valid, up_req_ready);
    end
    checks++;
    if (up_resp_valid !== 2'b00 || err !== 1'b0) begin
      failures++;
      $display("FAIL reset_resp up_resp_valid=%b err=%b want 00/0", up_resp_valid, err);
    end
    cyc(); cyc();
    rst = 1'b0; up_req_valid = 2'b00; req_ready = 1'b0;
  endtask

  task automatic test_round_robin();
    exp_grant = '{0, 1, 0, 1};
    up_req_valid = 2'b11; req_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      int g;
      #2;
      g = exp_grant.pop_front();
      checks++;
      if (req_valid !== 1'b1 || up_req_ready !== oh(g) || req_id !== exp_id(g)) begin
        failures++;
        $display("FAIL rr_grant%0d valid=%b ready=%b id=%h want 1/%b/%h",
                 k, req_valid, up_req_ready, req_id, oh(g), exp_id(g));
      end
      exp_route.push_back(g);
      exp_data.push_back(32'h11 * (k + 1));
      cyc();
    end
    up_req_valid = 2'b00; req_ready = 1'b0;
  endtask

  task automatic test_drain();
    int budget;
    budget = 0;
    up_resp_ready = 2'b11;
    while (exp_route.size() > 0 && budget < 16) begin
      int          r;
      logic [31:0] d;
      r = exp_route.pop_front();
      d = exp_data.pop_front();
      resp_valid = 1'b1; resp_data = d;
      #2;
      checks++;
      if (up_resp_valid !== oh(r) || up_resp_data !== d || resp_ready !== 1'b1) begin
        failures++;
        $display("FAIL drain_route up_resp_valid=%b data=%h resp_ready=%b want %b/%h/1",
                 up_resp_valid, up_resp_data, resp_ready, oh(r), d);
      end
      cyc();
      budget++;
    end
    resp_valid = 1'b0;
  endtask

  task automatic test_lock();
    // Move rr_ptr to 1 so requester 1 would win without the lock.
    up_req_valid = 2'b01; req_ready = 1'b1;
    #2;
    checks++;
    if (up_req_ready !== 2'b01) begin
      failures++;
      $display("FAIL lock_pre ready=%b want 01", up_req_ready);
    end
    exp_route.push_back(0); exp_data.push_back(32'h55);
    cyc();
    req_ready = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      if (c == 2) up_req_valid = 2'b11;
      #2;
      checks++;
      if (req_valid !== 1'b1 || req_id !== exp_id(0) || req_data0 !== exp_d0(0)
          || up_req_ready !== 2'b00) begin
        failures++;
        $display("FAIL lock_hold%0d valid=%b id=%h d0=%h ready=%b want 1/%h/%h/00",
                 c, req_valid, req_id, req_data0, up_req_ready, exp_id(0), exp_d0(0));
      end
      cyc();
    end
    req_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #2;
      checks++;
      if (up_req_ready !== oh(k) || req_id !== exp_id(k)) begin
        failures++;
        $display("FAIL lock_hs%0d ready=%b id=%h want %b/%h",
                 k, up_req_ready, req_id, oh(k), exp_id(k));
      end
      exp_route.push_back(k); exp_data.push_back(32'h66 + k);
      cyc();
    end
    up_req_valid = 2'b00; req_ready = 1'b0;
  endtask

  task automatic test_full();
    up_req_valid = 2'b01; req_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #2;
      checks++;
      if (up_req_ready !== 2'b01) begin
        failures++;
        $display("FAIL full_fill%0d ready=%b want 01", k, up_req_ready);
      end
      exp_route.push_back(0); exp_data.push_back(32'h60 + k);
      cyc();
    end
    #2;
    checks++;
    if (req_valid !== 1'b0 || up_req_ready !== 2'b00) begin
      failures++;
      $display("FAIL full_block valid=%b ready=%b want 0/00", req_valid, up_req_ready);
    end
    // Pop and pending request together: only the pop may happen.
    up_resp_ready = 2'b11; resp_valid = 1'b1; resp_data = exp_data[0];
    #1;
    checks++;
    if (req_valid !== 1'b0 || resp_ready !== 1'b1 || up_resp_valid !== 2'b01) begin
      failures++;
      $display("FAIL full_popsame req_valid=%b resp_ready=%b up_resp_valid=%b want 0/1/01",
               req_valid, resp_ready, up_resp_valid);
    end
    void'(exp_route.pop_front()); void'(exp_data.pop_front());
    cyc();
    resp_valid = 1'b0;
    #2;
    checks++;
    if (req_valid !== 1'b1 || up_req_ready !== 2'b01) begin
      failures++;
      $display("FAIL full_next valid=%b ready=%b want 1/01", req_valid, up_req_ready);
    end
    exp_route.push_back(0); exp_data.push_back(32'h70);
    cyc();
    up_req_valid = 2'b00; req_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    up_req_valid = 2'b10; req_ready = 1'b1;
    #2;
    checks++;
    if (up_req_ready !== 2'b10) begin
      failures++;
      $display("FAIL bp_req ready=%b want 10", up_req_ready);
    end
    cyc();
    up_req_valid = 2'b00; req_ready = 1'b0;
    resp_valid = 1'b1; resp_data = 32'hBEEF_0001; up_resp_ready = 2'b01;
    for (int c = 0; c < 2; c++) begin
      #2;
      checks++;
      if (resp_ready !== 1'b0 || up_resp_valid !== 2'b10) begin
        failures++;
        $display("FAIL bp_stall%0d resp_ready=%b up_resp_valid=%b want 0/10",
                 c, resp_ready, up_resp_valid);
      end
      cyc();
    end
    up_resp_ready = 2'b10;
    #2;
    checks++;
    if (resp_ready !== 1'b1 || up_resp_valid !== 2'b10 || up_resp_data !== 32'hBEEF_0001) begin
      failures++;
      $display("FAIL bp_release resp_ready=%b up_resp_valid=%b data=%h want 1/10/beef0001",
               resp_ready, up_resp_valid, up_resp_data);
    end
    cyc();
    #2;
    checks++;
    if (up_resp_valid !== 2'b00) begin
      failures++;
      $display("FAIL bp_empty up_resp_valid=%b want 00", up_resp_valid);
    end
    resp_valid = 1'b0;
  endtask

  task automatic test_err();
    cyc();
    resp_valid = 1'b1; resp_data = 32'hDEAD_0000;
    #2;
    checks++;
    if (resp_ready !== 1'b1 || up_resp_valid !== 2'b00 || err !== 1'b0) begin
      failures++;
      $display("FAIL err_drain resp_ready=%b up_resp_valid=%b err=%b want 1/00/0",
               resp_ready, up_resp_valid, err);
    end
    cyc();
    resp_valid = 1'b0;
    #2;
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL err_set err=%b want 1", err);
    end
    repeat (3) cyc();
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL err_sticky err=%b want 1", err);
    end
  endtask

  task automatic test_clk_en();
    clk_en = 1'b0; up_req_valid = 2'b01; req_ready = 1'b1;
    #2;
    checks++;
    if (req_valid !== 1'b1 || up_req_ready !== 2'b01) begin
      failures++;
      $display("FAIL cen_comb valid=%b ready=%b want 1/01", req_valid, up_req_ready);
    end
    cyc(); cyc();
    clk_en = 1'b1; up_req_valid = 2'b11; req_ready = 1'b0; resp_valid = 1'b1;
    #2;
    checks++;
    if (req_id !== exp_id(0) || up_resp_valid !== 2'b00) begin
      failures++;
      $display("FAIL cen_hold id=%h up_resp_valid=%b want %h/00",
               req_id, up_resp_valid, exp_id(0));
    end
    up_req_valid = 2'b00; resp_valid = 1'b0;
    cyc();
  endtask

  task automatic test_reset_mid();
    exp_grant = '{0, 1, 0};
    up_req_valid = 2'b11; req_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      int g;
      #2;
      g = exp_grant.pop_front();
      checks++;
      if (up_req_ready !== oh(g)) begin
        failures++;
        $display("FAIL rstmid_grant%0d ready=%b want %b", k, up_req_ready, oh(g));
      end
      cyc();
    end
    resp_valid = 1'b1; up_resp_ready = 2'b11; rst = 1'b1;
    #1;
    checks++;
    if (req_valid !== 1'b0 || up_req_ready !== 2'b00 || up_resp_valid !== 2'b00
        || err !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_async valid=%b ready=%b up_resp_valid=%b err=%b want 0/00/00/0",
               req_valid, up_req_ready, up_resp_valid, err);
    end
    cyc();
    rst = 1'b0; up_req_valid = 2'b00;
    #2;
    checks++;
    if (up_resp_valid !== 2'b00 || resp_ready !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_empty up_resp_valid=%b resp_ready=%b want 00/1",
               up_resp_valid, resp_ready);
    end
    resp_valid = 1'b0; up_req_valid = 2'b11; req_ready = 1'b0;
    #1;
    checks++;
    if (req_id !== exp_id(0)) begin
      failures++;
      $display("FAIL rstmid_rrptr id=%h want %h", req_id, exp_id(0));
    end
    up_req_valid = 2'b00;
    exp_route.delete(); exp_data.delete();
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; clk_en = 1'b1;
    up_req_valid = '0; req_ready = 1'b0; up_resp_ready = '0;
    up_req_id = {4'hC, 4'h5}; up_req_cxu = 2'b10; up_req_state = 2'b01;
    up_req_func = {10'h155, 10'h0AA};
    up_req_data0 = {32'hB1B1_0001, 32'hA0A0_0000};
    up_req_data1 = {32'h2222_2222, 32'h1111_1111};
    resp_valid = 1'b0; resp_id = 4'h7; resp_status = '0; resp_data = '0;
    test_reset();
    test_round_robin();
    test_drain();
    test_lock();
    test_drain();
    test_full();
    test_drain();
    test_backpressure();
    test_err();
    test_clk_en();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
